// File: rtl/acc_seq_ctrl.sv
// Multi-operand accumulator wrapped around an external combinational N-bit adder.
// Optional signed overflow flag (out_ovf) is compiled in with `define SIGNED_OVF_EN.
module acc_seq_ctrl #(
   parameter int N     = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             in_valid,
   input  logic [N-1:0]     in_data,
   output logic             in_ready,
   output logic [N-1:0]     add_a,
   output logic [N-1:0]     add_b,
   input  logic [N-1:0]     add_s,
   input  logic             add_cout,
   output logic             out_valid,
   output logic [N-1:0]     out_sum,
   output logic             out_carry,
   input  logic             out_ready,
   output logic             busy
`ifdef SIGNED_OVF_EN
   ,
   output logic             out_ovf
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ADD  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [N-1:0]     acc;
   logic [N-1:0]     opnd;
   logic [CNT_W-1:0] remaining;
   logic             carry_flag;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (start)    state_n = (len == '0) ? DONE : LOAD;
         LOAD: if (in_valid) state_n = ADD;
         ADD:  state_n = (remaining == CNT_W'(1)) ? DONE : LOAD;
         DONE: if (out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // The adder output is only sampled in ADD, a full cycle after opnd settles.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= '0;
         opnd       <= '0;
         remaining  <= '0;
         carry_flag <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               acc        <= '0;
               carry_flag <= 1'b0;
               remaining  <= len;
            end
            LOAD: if (in_valid) opnd <= in_data;
            ADD: begin
               acc        <= add_s;
               carry_flag <= carry_flag | add_cout;
               remaining  <= remaining - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef SIGNED_OVF_EN
   logic ovf_flag;

   always_ff @(posedge clk) begin
      if (rst)
         ovf_flag <= 1'b0;
      else if (state == IDLE && start)
         ovf_flag <= 1'b0;
      else if (state == ADD && add_a[N-1] == add_b[N-1] && add_s[N-1] != add_a[N-1])
         ovf_flag <= 1'b1;
   end

   assign out_ovf = ovf_flag;
`endif

   assign in_ready  = (state == LOAD);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign add_a     = acc;
   assign add_b     = opnd;
   assign out_sum   = acc;
   assign out_carry = carry_flag;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Bench for acc_seq_ctrl: directed vector table, corner sequences and random runs vs a sum model.
module tb_acc_seq_ctrl;
   localparam int N  = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst, start, in_valid, out_ready;
   logic [CW-1:0] len;
   logic [N-1:0]  in_data;
   logic          in_ready, out_valid, out_carry, busy, add_cout;
   logic [N-1:0]  add_a, add_b, add_s, out_sum;
`ifdef SIGNED_OVF_EN
   logic          out_ovf;
`endif

   always #5 clk = ~clk;

   // Behavioural stand-in for the ripple-carry adder.
   assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b};

   acc_seq_ctrl #(.N(N), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .add_a(add_a), .add_b(add_b), .add_s(add_s), .add_cout(add_cout),
      .out_valid(out_valid), .out_sum(out_sum), .out_carry(out_carry),
      .out_ready(out_ready), .busy(busy)
`ifdef SIGNED_OVF_EN
      , .out_ovf(out_ovf)
`endif
   );

   int checks = 0;
   int errors = 0;
   logic [N-1:0] opbuf [16];

   typedef struct {
      int           n;
      logic [N-1:0] op0, op1, op2, op3;
      int           gap;
      int           hold;
      logic [N-1:0] exp_sum;
      logic         exp_carry;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Result of a run from whole-run arithmetic: wrapped total, carry iff the total ever exceeded 2^N-1.
   function automatic void model(input int n, output logic [N-1:0] s, output logic c, output logic o);
      int tot;
      int sv;
      int a;
      tot = 0;
      a   = 0;
      o   = 1'b0;
      for (int i = 0; i < n; i++) begin
         tot += int'(opbuf[i]);
         sv = a + int'($signed(opbuf[i]));
         if (sv > 127 || sv < -128) o = 1'b1;
         a = (sv + 256) % 256;
         if (a > 127) a = a - 256;
      end
      s = N'(tot % 256);
      c = (tot > 255);
   endfunction

   // One complete run: returns clocks-to-out_valid (start edge counted) and number of in_ready cycles.
   task automatic run(input string nm, input int n, input int gap, input int hold,
                      input logic [N-1:0] es, input logic ec, output int lat, output int rdy);
      int idx;
      int g;
      idx = 0;
      g   = 0;
      rdy = 0;
      start = 1'b1;
      len   = CW'(n);
      in_valid = 1'b0;
      tick();
      start = 1'b0;
      lat = 1;
      while (!out_valid && lat < 300) begin
         if (in_ready) begin
            rdy++;
            if (g < gap || idx >= n) begin
               in_valid = 1'b0;
               g++;
            end else begin
               in_valid = 1'b1;
               in_data  = opbuf[idx];
               idx++;
               g = 0;
            end
         end else begin
            in_valid = 1'b1;       // junk offered outside LOAD must be ignored
            in_data  = N'($urandom);
         end
         tick();
         lat++;
      end
      in_valid = 1'b0;
      chk({nm, " out_valid"}, out_valid, 1);
      chk({nm, " sum"}, out_sum, es);
      chk({nm, " carry"}, out_carry, ec);
      for (int h = 0; h < hold; h++) begin
         start = (h == 1);
         len   = 4'd3;
         tick();
         start = 1'b0;
         chk({nm, " hold valid"}, out_valid, 1);
         chk({nm, " hold sum"}, out_sum, es);
         chk({nm, " hold in_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({nm, " idle busy"}, busy, 0);
      chk({nm, " idle valid"}, out_valid, 0);
      chk({nm, " idle sum kept"}, out_sum, es);
      chk({nm, " idle carry kept"}, out_carry, ec);
   endtask

   vec_t vt [6];

   initial begin
      int lat, rdy;
      logic [N-1:0] ms;
      logic mc, mo;

      vt[0] = '{3, 8'h10, 8'h20, 8'h30, 8'h00, 0, 0, 8'h60, 1'b0};
      vt[1] = '{2, 8'hFF, 8'h02, 8'h00, 8'h00, 0, 0, 8'h01, 1'b1};
      vt[2] = '{0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 1'b0};
      vt[3] = '{1, 8'h05, 8'h00, 8'h00, 8'h00, 0, 5, 8'h05, 1'b0};
      vt[4] = '{3, 8'h01, 8'h02, 8'h03, 8'h00, 3, 0, 8'h06, 1'b0};
      vt[5] = '{4, 8'h80, 8'h80, 8'h80, 8'h80, 0, 0, 8'h00, 1'b1};

      rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      tick();
      tick();
      chk("rst in_ready", in_ready, 0);
      chk("rst out_valid", out_valid, 0);
      chk("rst out_sum", out_sum, 0);
      chk("rst out_carry", out_carry, 0);
      chk("rst busy", busy, 0);
      chk("rst add_a", add_a, 0);
      chk("rst add_b", add_b, 0);
      rst = 1'b0;
      tick();

      for (int v = 0; v < 6; v++) begin
         opbuf[0] = vt[v].op0; opbuf[1] = vt[v].op1;
         opbuf[2] = vt[v].op2; opbuf[3] = vt[v].op3;
         run($sformatf("vec%0d", v), vt[v].n, vt[v].gap, vt[v].hold,
             vt[v].exp_sum, vt[v].exp_carry, lat, rdy);
         chk($sformatf("vec%0d latency", v), lat, 2 * vt[v].n + 1 + vt[v].gap * vt[v].n);
         chk($sformatf("vec%0d in_ready cycles", v), rdy, vt[v].n * (1 + vt[v].gap));
      end

      // Reset in the middle of a run discards the partial sum.
      start = 1'b1; len = 4'd3;
      tick();
      start = 1'b0; in_valid = 1'b1; in_data = 8'h10;
      tick();
      in_valid = 1'b0;
      tick();
      chk("midrst pre add_a", add_a, 8'h10);
      chk("midrst pre in_ready", in_ready, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst busy", busy, 0);
      chk("midrst out_valid", out_valid, 0);
      chk("midrst add_a", add_a, 0);
      chk("midrst add_b", add_b, 0);
      chk("midrst in_ready", in_ready, 0);
      opbuf[0] = 8'h07;
      run("after rst", 1, 0, 0, 8'h07, 1'b0, lat, rdy);
      chk("after rst latency", lat, 3);

`ifdef SIGNED_OVF_EN
      opbuf[0] = 8'h7F; opbuf[1] = 8'h01;
      run("ovf pos", 2, 0, 1, 8'h80, 1'b0, lat, rdy);
      chk("ovf pos flag", out_ovf, 1);
      opbuf[0] = 8'h80; opbuf[1] = 8'h80;
      run("ovf neg", 2, 0, 1, 8'h00, 1'b1, lat, rdy);
      chk("ovf neg flag", out_ovf, 1);
      opbuf[0] = 8'h05; opbuf[1] = 8'hFE;
      run("ovf none", 2, 0, 0, 8'h03, 1'b1, lat, rdy);
      chk("ovf none flag", out_ovf, 0);
`endif

      for (int r = 0; r < 40; r++) begin
         int n, gap;
         n   = int'($urandom_range(0, 7));
         gap = int'($urandom_range(0, 2));
         for (int i = 0; i < n; i++) opbuf[i] = N'($urandom);
         model(n, ms, mc, mo);
         run($sformatf("rnd%0d", r), n, gap, int'($urandom_range(0, 2)), ms, mc, lat, rdy);
         chk($sformatf("rnd%0d latency", r), lat, 2 * n + 1 + gap * n);
`ifdef SIGNED_OVF_EN
         chk($sformatf("rnd%0d ovf", r), out_ovf, mo);
`endif
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/acc_seq_ctrl.md
Name: acc_seq_ctrl

Overview:
Sequential controller that sits around the combinational N-bit ripple-carry adder, on both sides of it. Upstream, it registers a stream of operands and drives the adder's A/B inputs. Downstream, it captures the adder's sum and carry-out into an accumulator. After a programmed number of operands it presents the final sum with a valid/ready handshake. It turns the combinational adder into a multi-operand accumulation unit.

Parameters:
N, 8, datapath width; must match the adder width.
CNT_W, 4, width of the operand-count field; up to 2^CNT_W-1 operands per run.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  begin a run; sampled only in IDLE.
len  in  CNT_W  number of operands for the run; sampled with start.
in_valid  in  1  operand on in_data is valid.
in_data  in  N  operand.
in_ready  out  1  block accepts an operand this cycle.
add_a  out  N  to adder A; always equals the accumulator register.
add_b  out  N  to adder B; always equals the operand register.
add_s  in  N  from adder S.
add_cout  in  1  from adder Cout.
out_valid  out  1  result available.
out_sum  out  N  final accumulated sum.
out_carry  out  1  sticky OR of every add_cout captured during the run.
out_ready  in  1  consumer accepts the result.
busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset is synchronous and active-high: on rst at a clock edge, the state goes to IDLE, and the acc, opnd, remaining and carry_flag registers clear to 0.
  - Resulting outputs: in_ready=0, out_valid=0, out_sum=0, out_carry=0, busy=0, add_a=0, add_b=0.
  - rst has priority over every other input in every state, including mid-run; any partial sum is discarded.
- FSM states: IDLE, LOAD, ADD, DONE.
- IDLE:
  - On start=1: acc<=0, carry_flag<=0, remaining<=len.
  - Next state is DONE if len==0, else LOAD.
  - in_valid is ignored in IDLE.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready: opnd<=in_data, next state ADD.
  - Otherwise stay in LOAD; no timeout.
- ADD (exactly one cycle):
  - in_ready=0.
  - Actions: acc<=add_s; carry_flag<=carry_flag|add_cout; remaining<=remaining-1.
  - Next state is DONE if remaining==1, else LOAD.
- DONE:
  - out_valid=1; out_sum=acc; out_carry=carry_flag.
  - Outputs stay stable until out_ready=1, then next state is IDLE.
  - out_sum and out_carry keep their values in IDLE until the next start.
- start is ignored while busy=1.
- in_valid is ignored in ADD and DONE; data offered then is not consumed.
- Arithmetic is modulo 2^N, i.e. wrap-around. There is no saturation.
- The adder is purely combinational. add_s/add_cout are sampled only in ADD, one cycle after opnd is loaded, so no combinational path crosses the adder twice.
- Latency with in_valid held high: out_valid rises 2*len+1 clocks after the edge that samples start. For len=0 this is 1 clock.
- Throughput: one operand every 2 cycles at best.

Optional Feature:
SIGNED_OVF_EN
- Defined: adds output port out_ovf (1 bit).
  - It is a sticky flag set in ADD when add_a[N-1]==add_b[N-1] and add_s[N-1]!=add_a[N-1], i.e. two's-complement overflow.
  - Cleared by rst and by an accepted start; valid alongside out_valid.
- Not defined: the out_ovf port and its logic are absent; the rest of the behaviour is identical.

Test Plan:
- start, len=3, operands 0x10,0x20,0x30 with in_valid high -> out_valid 7 clocks after start; out_sum=0x60, out_carry=0.
- start, len=2, operands 0xFF,0x02 -> out_sum=0x01, out_carry=1.
- start, len=0 -> out_valid the next clock with out_sum=0x00, out_carry=0; no in_ready pulse.
- Back-pressure and stalls, len=1 operand 0x05:
  - out_ready held low 5 clocks, with start pulsed during DONE -> out_valid/out_sum=0x05 stay stable and start is ignored.
  - Then out_ready=1 -> IDLE and busy=0.
  - in_valid gaps of 3 clocks in LOAD -> correct sum, with the state waiting in LOAD.
- rst in LOAD after one of three operands accepted -> next clock: IDLE, busy=0, out_valid=0, add_a=0. A following run with len=1 and operand 0x07 -> out_sum=0x07.
- With SIGNED_OVF_EN, len=2, operands 0x7F,0x01 -> out_sum=0x80, out_ovf=1, out_carry=0. Operands 0x80,0x80 -> out_sum=0x00, out_ovf=1, out_carry=1.
